// File: rtl/hc595_pkg.sv
// hc595_pkg: shared types and constants for the 74HC595 pattern driver.
//   - ser_state_t  : serializer FSM states
//   - hc595_byte_t : one parallel byte presented to the 595
//   - next_pattern : free-running pattern step (wraps 0xFF -> 0x00)
package hc595_pkg;

    localparam int unsigned HC595_WIDTH = 8;
    localparam int unsigned HC595_IDX_W = 3;
    localparam int unsigned HC595_GAP_W = 16;

    typedef enum logic [1:0] {
        SER_IDLE     = 2'd0,
        SER_SHIFT_LO = 2'd1,
        SER_SHIFT_HI = 2'd2,
        SER_LATCH    = 2'd3
    } ser_state_t;

    typedef logic [HC595_WIDTH-1:0] hc595_byte_t;
    typedef logic [HC595_IDX_W-1:0] hc595_idx_t;

    // Next value of the free-running byte pattern.
    function automatic hc595_byte_t next_pattern(input hc595_byte_t cur);
        return cur + HC595_WIDTH'(1);
    endfunction

endpackage

// File: rtl/hc595_serializer.sv
// hc595_serializer: shifts one byte MSB-first into a 74HC595 and pulses RCLK.
// Optional macro HC595_OE_EN adds the latch_done_c strobe used for OE control.
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset
//   data, enable   : byte and request; accepted when enable && ready
//   ser, srclk     : serial data / shift clock to the 595 (registered)
//   rclk           : storage-latch clock to the 595 (registered)
//   latch_done_c   : (HC595_OE_EN only) high in the last LATCH cycle
//   ready          : high while the serializer is idle (registered)
module hc595_serializer
    import hc595_pkg::*;
#(
    parameter int unsigned CLK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  hc595_byte_t data,
    input  logic        enable,
    output logic        ser,
    output logic        srclk,
    output logic        rclk,
`ifdef HC595_OE_EN
    output logic        latch_done_c,
`endif
    output logic        ready
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    ser_state_t        state;
    hc595_byte_t       shreg;
    hc595_idx_t        idx;
    hc595_idx_t        idx_dec;
    logic [DIV_W-1:0]  div_cnt;
    logic              div_last;

    assign idx_dec  = idx - HC595_IDX_W'(1);
    // Every SRCLK/RCLK phase lasts CLK_DIV cycles.
    assign div_last = (div_cnt == DIV_W'(CLK_DIV - 1));

`ifdef HC595_OE_EN
    assign latch_done_c = (state == SER_LATCH) && div_last;
`endif

    // Serializer FSM: outputs are set on the edge that enters each state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= SER_IDLE;
            shreg   <= '0;
            idx     <= '0;
            div_cnt <= '0;
            ser     <= 1'b0;
            srclk   <= 1'b0;
            rclk    <= 1'b0;
            ready   <= 1'b1;
        end else begin
            case (state)
                SER_IDLE: begin
                    ser     <= 1'b0;
                    srclk   <= 1'b0;
                    rclk    <= 1'b0;
                    ready   <= 1'b1;
                    div_cnt <= '0;
                    // Gate on ready even though the sequencer never requests while busy.
                    if (enable && ready) begin
                        shreg <= data;
                        idx   <= HC595_IDX_W'(HC595_WIDTH - 1);
                        ser   <= data[HC595_WIDTH-1];
                        ready <= 1'b0;
                        state <= SER_SHIFT_LO;
                    end
                end

                SER_SHIFT_LO: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        srclk   <= 1'b1;
                        state   <= SER_SHIFT_HI;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                SER_SHIFT_HI: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        srclk   <= 1'b0;
                        if (idx == '0) begin
                            ser   <= 1'b0;
                            rclk  <= 1'b1;
                            state <= SER_LATCH;
                        end else begin
                            idx   <= idx_dec;
                            ser   <= shreg[idx_dec];
                            state <= SER_SHIFT_LO;
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                SER_LATCH: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        rclk    <= 1'b0;
                        ready   <= 1'b1;
                        state   <= SER_IDLE;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                default: begin
                    state <= SER_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/hc595_pattern_driver.sv
// hc595_pattern_driver: drives a 74HC595 with a free-running incrementing byte.
// A sequencer waits N ready cycles, hands the pattern byte to hc595_serializer,
// then increments the pattern. Optional macro HC595_OE_EN adds o_OE_n, which
// keeps the 595 outputs disabled until the first byte has been latched.
// Parameters:
//   N       : idle ready cycles between transfers (0..65535)
//   CLK_DIV : i_clk cycles per SRCLK/RCLK phase (>= 1)
// Ports:
//   i_clk, i_rst_n          : clock, synchronous active-low reset
//   o_OE_n                  : (HC595_OE_EN only) 595 output enable, active low
//   o_SER, o_SRCLK, o_RCLK  : 595 serial data, shift clock, latch clock
//   o_Ready                 : serializer idle
//   o_Data                  : byte most recently accepted by the serializer
module hc595_pattern_driver
    import hc595_pkg::*;
#(
    parameter int unsigned N       = 4,
    parameter int unsigned CLK_DIV = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
`ifdef HC595_OE_EN
    output logic                   o_OE_n,
`endif
    output logic                   o_SER,
    output logic                   o_SRCLK,
    output logic                   o_RCLK,
    output logic                   o_Ready,
    output logic [HC595_WIDTH-1:0] o_Data
);

    logic [HC595_GAP_W-1:0] gap_cnt;
    hc595_byte_t            pattern;
    logic                   enable_c;
    logic                   accept_c;
`ifdef HC595_OE_EN
    logic                   latch_done_c;
`endif

    // Request in the ready cycle whose index equals N.
    assign enable_c = o_Ready && (gap_cnt == HC595_GAP_W'(N));
    assign accept_c = enable_c && o_Ready;

    // Sequencer: gap counter, pattern counter and the accepted-byte register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            gap_cnt <= '0;
            pattern <= '0;
            o_Data  <= '0;
        end else if (accept_c) begin
            gap_cnt <= '0;
            pattern <= next_pattern(pattern);
            o_Data  <= pattern;
        end else if (o_Ready) begin
            gap_cnt <= gap_cnt + HC595_GAP_W'(1);
        end
    end

    hc595_serializer #(
        .CLK_DIV (CLK_DIV)
    ) u_serializer (
        .clk          (i_clk),
        .rst_n        (i_rst_n),
        .data         (pattern),
        .enable       (enable_c),
        .ser          (o_SER),
        .srclk        (o_SRCLK),
        .rclk         (o_RCLK),
`ifdef HC595_OE_EN
        .latch_done_c (latch_done_c),
`endif
        .ready        (o_Ready)
    );

`ifdef HC595_OE_EN
    // Outputs stay tri-stated until the end of the first latch pulse.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_OE_n <= 1'b1;
        end else if (latch_done_c) begin
            o_OE_n <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_hc595_pattern_driver.sv
// Directed bench for hc595_pattern_driver: instance A (N=4, CLK_DIV=1) and
// instance B (N=0, CLK_DIV=3). Outputs are sampled on the falling edge.
module tb_hc595_pattern_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n_a, rst_n_b;
    logic       ser_a, srclk_a, rclk_a, ready_a;
    logic [7:0] data_a;
    logic       ser_b, srclk_b, rclk_b, ready_b;
    logic [7:0] data_b;
`ifdef HC595_OE_EN
    logic       oe_n_a, oe_n_b;
`endif

    int checks = 0;
    int errors = 0;

    hc595_pattern_driver #(.N(4), .CLK_DIV(1)) dut_a (
        .i_clk   (clk),
        .i_rst_n (rst_n_a),
`ifdef HC595_OE_EN
        .o_OE_n  (oe_n_a),
`endif
        .o_SER   (ser_a),
        .o_SRCLK (srclk_a),
        .o_RCLK  (rclk_a),
        .o_Ready (ready_a),
        .o_Data  (data_a)
    );

    hc595_pattern_driver #(.N(0), .CLK_DIV(3)) dut_b (
        .i_clk   (clk),
        .i_rst_n (rst_n_b),
`ifdef HC595_OE_EN
        .o_OE_n  (oe_n_b),
`endif
        .o_SER   (ser_b),
        .o_SRCLK (srclk_b),
        .o_RCLK  (rclk_b),
        .o_Ready (ready_b),
        .o_Data  (data_b)
    );

    // Reset held 3 cycles; outputs must sit at reset values throughout.
    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({ser_a, srclk_a, rclk_a, ready_a} !== 4'b0001 || data_a !== 8'h00) begin
                errors++;
                $display("FAIL reset cyc%0d ser/srclk/rclk/ready=%b%b%b%b data=%h exp 0001 data 00",
                         i, ser_a, srclk_a, rclk_a, ready_a, data_a);
            end
`ifdef HC595_OE_EN
            checks++;
            if (oe_n_a !== 1'b1) begin
                errors++;
                $display("FAIL reset_oe got %b exp 1", oe_n_a);
            end
`endif
        end
        rst_n_a = 1'b1;
    endtask

    // Cycles 0..44 after release: accepts at 4 (byte 00) and 26 (byte 01).
    task automatic test_first_transfers();
        int t, u;
        logic busy, ser_e, srclk_e, rclk_e, ready_e;
        logic [7:0] b;
        for (int c = 0; c <= 44; c++) begin
            if (c > 0) @(negedge clk);
            t = (c > 26) ? 26 : 4;
            b = (c > 26) ? 8'h01 : 8'h00;
            u = c - t - 1;
            busy    = (u >= 0) && (u <= 16);
            srclk_e = busy && (u < 16) && (u % 2 == 1);
            rclk_e  = busy && (u == 16);
            ser_e   = (busy && u < 16) ? b[7 - u/2] : 1'b0;
            ready_e = !busy;
            checks++;
            if (srclk_a !== srclk_e) begin
                errors++;
                $display("FAIL first_srclk c=%0d got %b exp %b", c, srclk_a, srclk_e);
            end
            checks++;
            if (ser_a !== ser_e) begin
                errors++;
                $display("FAIL first_ser c=%0d got %b exp %b", c, ser_a, ser_e);
            end
            checks++;
            if (rclk_a !== rclk_e) begin
                errors++;
                $display("FAIL first_rclk c=%0d got %b exp %b", c, rclk_a, rclk_e);
            end
            checks++;
            if (ready_a !== ready_e) begin
                errors++;
                $display("FAIL first_ready c=%0d got %b exp %b", c, ready_a, ready_e);
            end
            checks++;
            if (data_a !== b) begin
                errors++;
                $display("FAIL first_data c=%0d got %h exp %h", c, data_a, b);
            end
`ifdef HC595_OE_EN
            checks++;
            if (oe_n_a !== (c < 22)) begin
                errors++;
                $display("FAIL first_oe c=%0d got %b exp %b", c, oe_n_a, (c < 22));
            end
`endif
        end
    endtask

    // Model 595 across 300 transfers (bytes 02..2D, wrapping through FF->00).
    task automatic test_wrap_595();
        logic       prev_s, prev_r;
        logic [7:0] sr, exp;
        int         n;
        prev_s = srclk_a;
        prev_r = rclk_a;
        sr     = 8'h00;
        exp    = 8'h02;
        n      = 0;
        for (int i = 0; i < 300 * 22 + 50 && n < 300; i++) begin
            @(negedge clk);
            if (srclk_a && !prev_s) sr = {sr[6:0], ser_a};
            if (rclk_a && !prev_r) begin
                checks++;
                if (sr !== exp) begin
                    errors++;
                    $display("FAIL wrap_latched n=%0d got %h exp %h", n, sr, exp);
                end
                checks++;
                if (sr !== data_a) begin
                    errors++;
                    $display("FAIL wrap_vs_data n=%0d latched %h o_Data %h", n, sr, data_a);
                end
                exp = exp + 8'h01;
                n++;
            end
            prev_s = srclk_a;
            prev_r = rclk_a;
        end
        checks++;
        if (n != 300) begin
            errors++;
            $display("FAIL wrap_count got %0d exp 300", n);
        end
    endtask

    // Reset at t+9 of a transfer: no latch, reset values, then byte 00 again.
    task automatic test_reset_mid();
        logic       prev_r, prev_s, found;
        logic [7:0] sr;
        found  = 1'b0;
        prev_r = ready_a;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (ready_a == 1'b0 && prev_r == 1'b1) found = 1'b1;
            prev_r = ready_a;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL mid_find_accept got none exp ready fall within 60 cycles");
        end
        for (int k = 2; k <= 9; k++) begin
            @(negedge clk);
            checks++;
            if (rclk_a !== 1'b0) begin
                errors++;
                $display("FAIL mid_rclk t+%0d got %b exp 0", k, rclk_a);
            end
        end
        rst_n_a = 1'b0;
        @(negedge clk);
        checks++;
        if ({ser_a, srclk_a, rclk_a, ready_a} !== 4'b0001 || data_a !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset_vals ser/srclk/rclk/ready=%b%b%b%b data=%h exp 0001 data 00",
                     ser_a, srclk_a, rclk_a, ready_a, data_a);
        end
`ifdef HC595_OE_EN
        checks++;
        if (oe_n_a !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_oe got %b exp 1", oe_n_a);
        end
`endif
        rst_n_a = 1'b1;
        sr      = 8'hFF;
        prev_s  = srclk_a;
        for (int c = 1; c <= 22; c++) begin
            @(negedge clk);
            if (srclk_a && !prev_s) sr = {sr[6:0], ser_a};
            prev_s = srclk_a;
            if (c == 5) begin
                checks++;
                if (ready_a !== 1'b0) begin
                    errors++;
                    $display("FAIL mid_accept c=5 ready got %b exp 0", ready_a);
                end
            end
            if (c == 21) begin
                checks++;
                if (rclk_a !== 1'b1) begin
                    errors++;
                    $display("FAIL mid_rclk_pulse c=21 got %b exp 1", rclk_a);
                end
                checks++;
                if (sr !== 8'h00 || data_a !== 8'h00) begin
                    errors++;
                    $display("FAIL mid_byte latched %h o_Data %h exp 00", sr, data_a);
                end
            end
            if (c == 22) begin
                checks++;
                if (ready_a !== 1'b1) begin
                    errors++;
                    $display("FAIL mid_ready c=22 got %b exp 1", ready_a);
                end
            end
        end
    endtask

    // CLK_DIV=3, N=0: 3-cycle phases, busy 51, period 52.
    task automatic test_clkdiv3();
        int u, j;
        logic busy, ser_e, srclk_e, rclk_e, ready_e;
        logic [7:0] b, data_e;
        rst_n_b = 1'b1;
        for (int c = 0; c <= 110; c++) begin
            if (c > 0) @(negedge clk);
            u = (c > 0) ? (c - 1) % 52 : 0;
            j = (c > 0) ? (c - 1) / 52 : 0;
            b = 8'(j);
            busy    = (c > 0) && (u <= 50);
            srclk_e = busy && (u < 48) && ((u / 3) % 2 == 1);
            rclk_e  = busy && (u >= 48);
            ser_e   = (busy && u < 48) ? b[7 - u/6] : 1'b0;
            ready_e = !busy;
            data_e  = (c > 0) ? b : 8'h00;
            checks++;
            if (srclk_b !== srclk_e || rclk_b !== rclk_e) begin
                errors++;
                $display("FAIL div3_clocks c=%0d srclk/rclk got %b%b exp %b%b",
                         c, srclk_b, rclk_b, srclk_e, rclk_e);
            end
            checks++;
            if (ser_b !== ser_e) begin
                errors++;
                $display("FAIL div3_ser c=%0d got %b exp %b", c, ser_b, ser_e);
            end
            checks++;
            if (ready_b !== ready_e) begin
                errors++;
                $display("FAIL div3_ready c=%0d got %b exp %b", c, ready_b, ready_e);
            end
            checks++;
            if (data_b !== data_e) begin
                errors++;
                $display("FAIL div3_data c=%0d got %h exp %h", c, data_b, data_e);
            end
`ifdef HC595_OE_EN
            checks++;
            if (oe_n_b !== (c < 52)) begin
                errors++;
                $display("FAIL div3_oe c=%0d got %b exp %b", c, oe_n_b, (c < 52));
            end
`endif
        end
    endtask

    initial begin
        rst_n_a = 1'b0;
        rst_n_b = 1'b0;
        test_reset();
        test_first_transfers();
        test_wrap_595();
        test_reset_mid();
        test_clkdiv3();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hc595_pattern_driver.md
# hc595_pattern_driver

Drives an external 74HC595 8-bit serial-in/parallel-out shift register from a free-running byte pattern. An internal sequencer produces an incrementing byte, hands it to a serializer over a ready/enable handshake, and waits a programmable gap between transfers. The serializer shifts the byte out MSB-first on SER/SRCLK and pulses RCLK to update the 595 outputs. The block sits at the board-I/O edge; its only inputs are clock and reset.

## Interface
- `N`, default 4: idle cycles between transfers, counted in serializer-ready cycles. Range 0..65535.
- `CLK_DIV`, default 1: duration of each SRCLK/RCLK phase, in `i_clk` cycles. Must be ≥1.
- `i_clk` in 1: system clock. All logic is on the rising edge.
- `i_rst_n` in 1: reset. One clock; reset is synchronous and active-low.
- `o_SER` out 1: serial data to 595 SER.
- `o_SRCLK` out 1: shift clock to 595 SRCLK.
- `o_RCLK` out 1: storage-latch clock to 595 RCLK.
- `o_Ready` out 1: high when the serializer is idle.
- `o_Data` out 8: byte most recently accepted by the serializer.
- `o_OE_n` out 1: present only with `HC595_OE_EN`.

## Operation
- All outputs are registered.
- **Reset values:**
  - `o_SER`, `o_SRCLK`, `o_RCLK` = 0.
  - `o_Ready` = 1.
  - `o_Data` = 0x00.
  - Pattern counter = 0x00; gap counter = 0.
  - `o_OE_n` = 1.
- **Sequencer:**
  - Counts consecutive cycles in which ready is high and enable is not asserted.
  - In the ready-high cycle whose index is N (0-based), it asserts the internal enable for exactly one cycle, with data equal to the pattern counter.
  - A transfer is accepted when enable and ready are both high in the same cycle.
  - On acceptance: pattern counter increments (0xFF wraps to 0x00), gap counter clears, and `o_Data` loads the byte.
- **Serializer FSM** (states IDLE, SHIFT_LO, SHIFT_HI, LATCH):
  - IDLE: ready=1, SER=0, SRCLK=0, RCLK=0. On accept: load shift register, set bit index to 7, go to SHIFT_LO.
  - SHIFT_LO: SER = data[idx], SRCLK=0, for CLK_DIV cycles, then go to SHIFT_HI.
  - SHIFT_HI: SER held, SRCLK=1, for CLK_DIV cycles. Then, if idx=0, go to LATCH; otherwise decrement idx and go to SHIFT_LO.
  - LATCH: SER=0, SRCLK=0, RCLK=1, for CLK_DIV cycles, then go to IDLE.
- Enable is ignored whenever ready is low. It cannot occur then by construction, but the serializer must still gate on ready.
- **Reset mid-transfer:** all state returns to reset values on the next edge. The partial byte is never latched, because RCLK stays 0.

## Timing
Cycle offsets below are relative to acceptance at cycle t, for CLK_DIV=1.
- t+1: SER = bit7, SRCLK=0, ready=0.
- Rising SRCLK for bit k occurs at t+2+2·(7−k), so bit7 at t+2 and bit0 at t+16.
- t+17: RCLK=1.
- t+18: RCLK=0, ready=1.
- Busy period is 17·CLK_DIV cycles in general.
- After reset release, the first cycle is index 0 with ready high, so the first enable/accept is at cycle N.
- Transfer period is 18+N cycles for CLK_DIV=1, or 17·CLK_DIV+1+N in general.
- N=0: enable in the first ready cycle, giving back-to-back transfers with a single idle cycle.

## Configuration
- `HC595_OE_EN` defined:
  - Adds port `o_OE_n` (out, 1 bit).
  - It stays 1 from reset until the end of the first LATCH state, then drives 0 until the next reset.
  - Purpose: the 595 outputs stay tri-stated until a valid byte is latched.
- `HC595_OE_EN` undefined: no port, no logic.

## Structure
- Package `hc595_pkg` holds:
  - Serializer state enum.
  - `HC595_WIDTH = 8`.
  - Bit-index width (3).
- Sub-module `hc595_serializer` contains the FSM, shift register, SER/SRCLK/RCLK outputs and `o_Ready`. It receives data and enable through the ready/enable handshake.
- The top level contains the sequencer (gap counter, pattern counter, `o_Data`) and the optional OE logic.

## Test plan
- Reset held 3 cycles, then released with N=4, CLK_DIV=1:
  - Outputs hold reset values during reset.
  - First accept at cycle 4.
  - `o_Data`=0x00.
  - 8 SRCLK rising edges, each with SER=0.
  - RCLK pulse at cycle 21.
  - Ready high at cycle 22.
- Second transfer:
  - Accept at cycle 26 (period 22), `o_Data`=0x01.
  - Only the last SRCLK edge samples SER=1.
- Check MSB-first ordering via a model 595: after each RCLK, its parallel output must equal `o_Data`. Run 300 transfers so the counter wraps 0xFF→0x00.
- With CLK_DIV=3, N=0:
  - Each SRCLK and RCLK phase lasts 3 cycles.
  - Busy period is 51 cycles; period is 52.
- Assert reset at t+9 of a transfer:
  - No RCLK pulse.
  - All outputs at reset values next cycle.
  - Next transfer sends 0x00.
- With `HC595_OE_EN`: `o_OE_n`=1 until the first RCLK falling edge, then 0.
